// File: rtl/key_input_conditioner.sv
// Conditions ten raw key levels into a settled chord vector with press/release strobes.
// Each bit is synchronised and debounced; the vector is published atomically after a settle time.
module key_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int SETTLE_CYCLES   = 500_000,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_keys,
  output logic [9:0] pin_out,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       any_key
);

  localparam int N = 10;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The capture edge is the first held cycle, so scnt lags the held-cycle count by one.
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 2);

  typedef enum logic {IDLE, SETTLING} state_t;

  logic [N-1:0] sync1_reg;
  logic [N-1:0] sync2_reg;
  logic [N-1:0] deb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_keys;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_deb
      logic [CNT_W-1:0] cnt_reg;
      logic             deb_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
          deb_reg <= 1'b0;
        end else if (sync2_reg[gi] == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DEB_LAST) begin
          deb_reg <= ~deb_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign deb[gi] = deb_reg;
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [N-1:0]     cand_reg, cand_next;
  logic [CNT_W-1:0] scnt_reg, scnt_next;
  logic             publish;
  logic [N-1:0]     pin_next;
  logic             press_next;
  logic             release_next;
  logic             any_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cand_reg      <= '0;
      scnt_reg      <= '0;
      pin_out       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      any_key       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cand_reg      <= cand_next;
      scnt_reg      <= scnt_next;
      pin_out       <= pin_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      any_key       <= any_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    scnt_next  = scnt_reg;
    publish    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (deb != pin_out) begin
          cand_next  = deb;
          scnt_next  = '0;
          state_next = SETTLING;
        end
      end
      SETTLING: begin
        if (deb == pin_out) begin
          state_next = IDLE;
        end else if (deb != cand_reg) begin
          cand_next = deb;
          scnt_next = '0;
        end else if (scnt_reg == SET_LAST) begin
          publish    = 1'b1;
          scnt_next  = '0;
          state_next = IDLE;
        end else begin
          scnt_next = scnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pin_next     = publish ? cand_reg : pin_out;
    press_next   = publish && (cand_reg != '0);
    release_next = publish && (cand_reg == '0);
    any_next     = |pin_next;
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Randomised and directed checks of key_input_conditioner against a run-length based model.
module tb_key_input_conditioner;

  localparam int D = 4;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] raw_keys = '0;
  logic [9:0] pin_out;
  logic       press_pulse;
  logic       release_pulse;
  logic       any_key;

  always #5 clk = ~clk;

  key_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SETTLE_CYCLES(S),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_keys(raw_keys),
    .pin_out(pin_out),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .any_key(any_key)
  );

  // Model: synchroniser as two-sample history, debounce as mismatch run length,
  // settle as the run length of an unpublished debounced value.
  logic [9:0] m_s1, m_s2, m_deb, m_pin, m_run_val;
  int         m_mis[10];
  int         m_run;
  bit         m_press, m_rel;

  int total = 0;
  int bad = 0;
  int n_press = 0;
  int n_rel = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_pin = '0; m_run_val = '0;
    m_run = 0; m_press = 0; m_rel = 0;
    for (int i = 0; i < 10; i++) m_mis[i] = 0;
  endtask

  task automatic model_edge();
    logic [9:0] deb_new;
    if (!rst) begin
      model_clear();
    end else begin
      deb_new = m_deb;
      for (int i = 0; i < 10; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_mis[i]++;
          if (m_mis[i] == D) begin
            deb_new[i] = ~m_deb[i];
            m_mis[i] = 0;
          end
        end else begin
          m_mis[i] = 0;
        end
      end
      m_press = 0;
      m_rel = 0;
      if (m_deb != m_pin) begin
        if (m_run > 0 && m_deb == m_run_val) m_run++;
        else begin
          m_run = 1;
          m_run_val = m_deb;
        end
        if (m_run == S) begin
          m_pin = m_deb;
          m_press = (m_deb != 0);
          m_rel = (m_deb == 0);
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = raw_keys;
      m_deb = deb_new;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (press_pulse) n_press++;
    if (release_pulse) n_rel++;
    check("pin_out", 32'(pin_out), 32'(m_pin));
    check("press", 32'(press_pulse), 32'(m_press));
    check("release", 32'(release_pulse), 32'(m_rel));
    check("any_key", 32'(any_key), 32'(|m_pin));
    check("excl", 32'(press_pulse & release_pulse), 32'd0);
    $display("cyc rst=%0b raw=%03h pin=%03h p=%0b r=%0b", rst, raw_keys, pin_out, press_pulse, release_pulse);
  endtask

  task automatic hold(input logic [9:0] v, input int n);
    raw_keys = v;
    repeat (n) step();
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    // 1: reset with all keys pressed, then latency
    rst = 1'b0;
    raw_keys = 10'h3FF;
    repeat (20) step();
    check("rst_pin", 32'(pin_out), 32'h0);
    check("rst_any", 32'(any_key), 32'h0);
    rst = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 7) check("lat_early", 32'(pin_out), 32'h0);
    end
    check("lat_pin", 32'(pin_out), 32'h3FF);
    check("lat_press", 32'(press_pulse), 32'h1);
    hold(10'h000, 20);

    // 2: glitch rejection
    n_press = 0; n_rel = 0;
    hold(10'h001, 3);
    hold(10'h000, 30);
    check("glitch_pulses", 32'(n_press + n_rel), 32'h0);

    // 3: staggered chord
    n_press = 0;
    hold(10'h001, 2);
    hold(10'h011, 15);
    check("chord_press", 32'(n_press), 32'h1);
    check("chord_pin", 32'(pin_out), 32'h011);
    hold(10'h000, 20);

    // 4: release then repeat
    hold(10'h040, 20);
    n_press = 0; n_rel = 0;
    hold(10'h000, 20);
    check("rel_once", 32'(n_rel), 32'h1);
    hold(10'h040, 20);
    check("repress_once", 32'(n_press), 32'h1);

    // 5: chord change
    hold(10'h003, 20);
    n_press = 0; n_rel = 0;
    hold(10'h00C, 20);
    check("chg_press", 32'(n_press), 32'h1);
    check("chg_rel", 32'(n_rel), 32'h0);
    check("chg_pin", 32'(pin_out), 32'h00C);
    hold(10'h000, 20);

    // 6: reset two edges before publish
    n_press = 0; n_rel = 0;
    hold(10'h200, 6);
    rst = 1'b0;
    repeat (2) step();
    check("midrst_pin", 32'(pin_out), 32'h0);
    check("midrst_pulses", 32'(n_press + n_rel), 32'h0);
    rst = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 7) check("relat_early", 32'(pin_out), 32'h0);
    end
    check("relat_pin", 32'(pin_out), 32'h200);

    // randomised segments
    for (int seg = 0; seg < 300; seg++) begin
      logic [9:0] v;
      case ($urandom_range(0, 3))
        0: v = '0;
        1: v = 10'(1 << $urandom_range(0, 9));
        2: v = 10'($urandom);
        default: v = raw_keys ^ 10'(1 << $urandom_range(0, 9));
      endcase
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        hold(v, $urandom_range(1, 3));
        rst = 1'b1;
      end
      hold(v, $urandom_range(1, 12));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
